// File: rtl/mdio_peripheral.sv
// mdio_peripheral: Clause 22 MDIO slave that turns frames into register-memory strobes.
// Define MDIO_PREAMBLE_CHECK_EN to require a 32-bit all-ones preamble before ST.
module mdio_peripheral #(
    parameter logic [4:0] PHY_ADDR = 5'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MDC,
    input  logic        MDIO_OUT,
    input  logic        MDIO_OE,
    input  logic [15:0] RD_DATA,
    output logic        MDIO_RESP,
    output logic        MDIO_RESP_OE,
    output logic [4:0]  ADDR,
    output logic [15:0] WR_DATA,
    output logic        MEMORY_WR,
    output logic        MEMORY_RD,
    output logic        FRAME_ERR
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_WR_TA,
        ST_WR_DATA,
        ST_RD_TA,
        ST_RD_DATA,
        ST_IGNORE
    } state_t;

    state_t      state, state_n;
    logic [4:0]  cnt, cnt_n;          // index of the last frame bit consumed
    logic [15:0] shreg, shreg_n;
    logic        mdc_q;
    logic        rd_cap;
    logic        resp_n, resp_oe_n, mem_wr_n, mem_rd_n, frame_err_n;
    logic [4:0]  addr_n;
    logic [15:0] wr_data_n;
    logic        rise, fall, sample;
    logic [13:0] hdr;
    logic        hdr_ok;
`ifdef MDIO_PREAMBLE_CHECK_EN
    logic [5:0]  ones, ones_n;
`endif

    assign rise   = MDC & ~mdc_q;
    assign fall   = ~MDC & mdc_q;
    assign sample = rise & MDIO_OE;
    assign hdr    = {shreg[12:0], MDIO_OUT};
    assign hdr_ok = (hdr[13:12] == 2'b01) && ((hdr[11:10] == 2'b01) || (hdr[11:10] == 2'b10));

    always_comb begin
        // NOTE: every value written here gets a default first, so no latch is inferred.
        state_n     = state;
        cnt_n       = cnt;
        shreg_n     = shreg;
        resp_n      = MDIO_RESP;
        resp_oe_n   = MDIO_RESP_OE;
        addr_n      = ADDR;
        wr_data_n   = WR_DATA;
        mem_wr_n    = 1'b0;
        mem_rd_n    = 1'b0;
        frame_err_n = 1'b0;
`ifdef MDIO_PREAMBLE_CHECK_EN
        ones_n      = ones;
`endif
        case (state)
            ST_IDLE: begin
`ifdef MDIO_PREAMBLE_CHECK_EN
                if (sample) begin
                    if (MDIO_OUT) begin
                        if (ones != 6'd32) ones_n = ones + 6'd1;
                    end else if (ones == 6'd32) begin
                        ones_n  = '0;
                        state_n = ST_HEADER;
                        cnt_n   = '0;
                        shreg_n = 16'd0;
                    end else begin
                        ones_n = '0;
                    end
                end
`else
                if (sample) begin
                    state_n = ST_HEADER;
                    cnt_n   = '0;
                    shreg_n = {15'd0, MDIO_OUT};
                end
`endif
            end
            ST_HEADER: begin
                if (sample) begin
                    shreg_n = {shreg[14:0], MDIO_OUT};
                    cnt_n   = cnt + 5'd1;
                    if (cnt == 5'd12) begin
                        if (!hdr_ok) begin
                            frame_err_n = 1'b1;
                            state_n     = ST_IGNORE;
                        end else if (hdr[9:5] != PHY_ADDR) begin
                            state_n = ST_IGNORE;
                        end else begin
                            addr_n = hdr[4:0];
                            if (hdr[11:10] == 2'b01) begin
                                state_n = ST_WR_TA;
                            end else begin
                                state_n  = ST_RD_TA;
                                mem_rd_n = 1'b1;
                            end
                        end
                    end
                end
            end
            ST_WR_TA, ST_WR_DATA: begin
                if (rise && !MDIO_OE) begin
                    frame_err_n = 1'b1;
                    state_n     = ST_IDLE;
                    cnt_n       = '0;
                end else if (rise) begin
                    shreg_n = {shreg[14:0], MDIO_OUT};
                    cnt_n   = cnt + 5'd1;
                    if (state == ST_WR_TA && cnt == 5'd14) begin
                        if ({shreg[0], MDIO_OUT} == 2'b10) begin
                            state_n = ST_WR_DATA;
                        end else begin
                            frame_err_n = 1'b1;
                            state_n     = ST_IGNORE;
                        end
                    end else if (state == ST_WR_DATA && cnt == 5'd30) begin
                        wr_data_n = {shreg[14:0], MDIO_OUT};
                        mem_wr_n  = 1'b1;
                        state_n   = ST_IDLE;
                        cnt_n     = '0;
                    end
                end
            end
            ST_RD_TA: begin
                if (rd_cap) shreg_n = RD_DATA;
                if (fall) begin
                    cnt_n = cnt + 5'd1;
                    // Second turnaround fall: take the bus and drive the TA zero.
                    if (cnt == 5'd14) begin
                        resp_oe_n = 1'b1;
                        resp_n    = 1'b0;
                        state_n   = ST_RD_DATA;
                    end
                end
            end
            ST_RD_DATA: begin
                if (fall) begin
                    if (cnt == 5'd31) begin
                        resp_oe_n = 1'b0;
                        resp_n    = 1'b0;
                        state_n   = ST_IDLE;
                        cnt_n     = '0;
                    end else begin
                        resp_n  = shreg[15];
                        shreg_n = {shreg[14:0], 1'b0};
                        cnt_n   = cnt + 5'd1;
                    end
                end
            end
            ST_IGNORE: begin
                if (rise) begin
                    if (cnt == 5'd30) begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 5'd1;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // NOTE: all registered state uses non-blocking assignments.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            shreg        <= '0;
            mdc_q        <= 1'b0;
            rd_cap       <= 1'b0;
            MDIO_RESP    <= 1'b0;
            MDIO_RESP_OE <= 1'b0;
            ADDR         <= '0;
            WR_DATA      <= '0;
            MEMORY_WR    <= 1'b0;
            MEMORY_RD    <= 1'b0;
            FRAME_ERR    <= 1'b0;
`ifdef MDIO_PREAMBLE_CHECK_EN
            ones         <= '0;
`endif
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            shreg        <= shreg_n;
            mdc_q        <= MDC;
            rd_cap       <= MEMORY_RD;
            MDIO_RESP    <= resp_n;
            MDIO_RESP_OE <= resp_oe_n;
            ADDR         <= addr_n;
            WR_DATA      <= wr_data_n;
            MEMORY_WR    <= mem_wr_n;
            MEMORY_RD    <= mem_rd_n;
            FRAME_ERR    <= frame_err_n;
`ifdef MDIO_PREAMBLE_CHECK_EN
            ones         <= ones_n;
`endif
        end
    end

endmodule
